bus_responder: RTL and testbench
================================

# bus_responder

Memory/IO responder for the 8085 multiplexed system bus. It is the target side of the bus cycles issued by the CPU timing/decoding logic:
- demultiplexes AD7..AD0 using ALE;
- classifies the cycle from IOMn/S1/S0;
- turns RDn/WRn strobes into single-cycle accesses on a synchronous backing-store port;
- stretches cycles with READY for a programmable number of wait states.

## Interface
Parameters:
- WAIT_STATES, default 0: wait cycles inserted per read/write, legal 0..7.

Ports (bus inputs are synchronous to phi1):
- phi1  in  1  single system clock, all state on rising edge
- resetn  in  1  reset, asynchronous, active-low
- ALE  in  1  address latch enable from CPU
- ad_in  in  8  AD bus as driven by CPU (address low byte, or write data)
- a_hi  in  8  A15..A8
- IOMn  in  1  1 = IO cycle, 0 = memory cycle
- S1, S0  in  1 each  cycle status; 11 = opcode fetch, 10 = read, 01 = write
- RDn, WRn  in  1 each  active-low strobes
- ad_out  out  8  read data driven onto AD
- ad_oe  out  1  AD output enable
- READY  out  1  0 = CPU must insert wait state
- fetch  out  1  latched "current cycle is opcode fetch"
- bus_err  out  1  one-cycle pulse on protocol error
- mem_addr  out  16  latched address {a_hi, ad_in}
- mem_io  out  1  latched IOMn
- mem_re  out  1  one-cycle read strobe
- mem_we  out  1  one-cycle write strobe
- mem_wdata  out  8  write data, valid with mem_we
- mem_rdata  in  8  read data, combinational from mem_addr while mem_re is high

## Operation
- States: IDLE, ADDR, RD_WAIT, RD_DRIVE, WR_WAIT, WR_DONE.
- ALE sampled high in any state:
  - latch mem_addr = {a_hi, ad_in}, mem_io = IOMn, fetch = S1&S0;
  - go to ADDR;
  - any access in progress is abandoned and no strobe is issued.
- ADDR:
  - RDn=0, WRn=1: load wait counter with WAIT_STATES, assert mem_re, go to RD_WAIT.
  - WRn=0, RDn=1: load wait counter, go to WR_WAIT.
  - RDn=0 and WRn=0: pulse bus_err, go to IDLE, no access.
- RD_WAIT:
  - capture mem_rdata into ad_out on the first edge only;
  - decrement the counter each edge;
  - at zero, go to RD_DRIVE.
- RD_DRIVE: hold ad_out; return to IDLE when RDn is sampled high.
- WR_WAIT:
  - decrement the counter each edge;
  - at zero, register mem_wdata = ad_in and pulse mem_we for one cycle;
  - then go to WR_DONE.
- WR_DONE: return to IDLE when WRn is sampled high.
- Strobe deasserted early (RDn or WRn high before the counter expires): return to IDLE.
  - Reads: no further effect.
  - Writes: mem_we is never issued.
- Counter arithmetic: 3-bit counter, never wraps; decrement saturates at 0.

## Timing
- Reset values: ad_out=0, ad_oe=0, READY=1, fetch=0, bus_err=0, mem_addr=0, mem_io=0, mem_re=0, mem_we=0, mem_wdata=0; state IDLE.
- Reset mid-cycle: all outputs return to reset values immediately. No strobe completes.
- Edge e0 is the edge that samples RDn/WRn low in ADDR.
- Read latency:
  - mem_re is high for exactly the cycle following e0;
  - ad_out is valid from e0+1;
  - READY is low from e0 to e0+W (W cycles; never low when W=0).
- ad_oe = (state ∈ {RD_WAIT, RD_DRIVE}) & ~RDn, gated combinationally. It drops in the same cycle RDn rises, so there is no bus contention.
- Write latency:
  - mem_we is high for the cycle following edge e0+W;
  - mem_wdata is ad_in as sampled at e0+W;
  - READY is low for W cycles from e0.
- Back-to-back cycles: ALE may be sampled on the edge that returns the block to IDLE. The new address is latched and the state goes to ADDR.

## Structure
- Package bus_pkg:
  - state enum;
  - S1S0 encodings (FETCH=2'b11, READ=2'b10, WRITE=2'b01, HALT=2'b00);
  - WAIT_STATES legal-range constant.
- One natural sub-module, ad_demux: the ALE-driven address/status latch (mem_addr, mem_io, fetch). The FSM, wait counter and data path stay in bus_responder.

## Test plan
- Fetch, W=0:
  - Stimulus: ALE with a_hi=8'h12, ad_in=8'h34, S1S0=11, IOMn=0; then RDn low; mem_rdata=8'h3E.
  - Response: mem_addr=16'h1234, fetch=1, mem_re one cycle, ad_out=8'h3E with ad_oe=1 until RDn high, READY stays 1.
- Memory write, W=2:
  - Stimulus: ALE with addr 16'h2000; WRn low with ad_in=8'hA5.
  - Response: READY low exactly 2 cycles; one mem_we with mem_wdata=8'hA5 at e0+2; no mem_re.
- IO read, W=3:
  - Stimulus: IOMn=1, addr 8'h40 on both halves.
  - Response: mem_io=1, mem_addr=16'h4040, READY low 3 cycles, ad_oe drops in the cycle RDn rises.
- Protocol error:
  - Stimulus: RDn and WRn both sampled low in ADDR.
  - Response: bus_err pulses once; mem_re=mem_we=0; state returns to IDLE.
- Abort and reset:
  - Write with W=4 and WRn raised after 2 cycles: no mem_we.
  - resetn low during RD_DRIVE: ad_oe=0 and READY=1 immediately, next ALE is accepted normally.
- Back-to-back:
  - Stimulus: read 16'h0001, then ALE on the IDLE-return edge for write 16'h0002.
  - Response: both accesses complete with correct addresses, no dead cycle required.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and constants for the 8085 bus responder.
package bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_RD_WAIT,
    ST_RD_DRIVE,
    ST_WR_WAIT,
    ST_WR_DONE
  } state_e;

  // S1,S0 cycle status encodings
  typedef enum logic [1:0] {
    S_HALT  = 2'b00,
    S_WRITE = 2'b01,
    S_READ  = 2'b10,
    S_FETCH = 2'b11
  } status_e;

  localparam int unsigned WAIT_MAX = 7;

  function automatic logic [2:0] sat_dec(input logic [2:0] v);
    return (v == 3'd0) ? 3'd0 : v - 3'd1;
  endfunction

endpackage

// File: rtl/bus_responder_if.sv
// CPU-side multiplexed bus bundle: the responder is the slave, the CPU the master.
interface bus_responder_if;
  logic       ALE;
  logic [7:0] ad_in;
  logic [7:0] a_hi;
  logic       IOMn;
  logic       S1;
  logic       S0;
  logic       RDn;
  logic       WRn;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       READY;

  modport slave (
    input  ALE, ad_in, a_hi, IOMn, S1, S0, RDn, WRn,
    output ad_out, ad_oe, READY
  );

  modport master (
    output ALE, ad_in, a_hi, IOMn, S1, S0, RDn, WRn,
    input  ad_out, ad_oe, READY
  );
endinterface

// File: rtl/ad_demux.sv
// ALE-driven latch for the demultiplexed address and cycle status.
module ad_demux
  import bus_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ale_i,
  input  logic [7:0]  ad_i,
  input  logic [7:0]  a_hi_i,
  input  logic        iomn_i,
  input  logic        s1_i,
  input  logic        s0_i,
  output logic [15:0] addr_o,
  output logic        io_o,
  output logic        fetch_o
);

  logic [15:0] addr_q;
  logic        io_q;
  logic        fetch_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      io_q    <= 1'b0;
      fetch_q <= 1'b0;
    end else if (ale_i) begin
      addr_q  <= {a_hi_i, ad_i};
      io_q    <= iomn_i;
      fetch_q <= (status_e'({s1_i, s0_i}) == S_FETCH);
    end
  end

  assign addr_o  = addr_q;
  assign io_o    = io_q;
  assign fetch_o = fetch_q;

endmodule

// File: rtl/bus_responder.sv
// 8085 bus target: turns RDn/WRn strobes into single-cycle backing-store accesses with wait states.
module bus_responder
  import bus_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic            phi1,
  input  logic            resetn,
  bus_responder_if.slave  bus,
  output logic            fetch,
  output logic            bus_err,
  output logic [15:0]     mem_addr,
  output logic            mem_io,
  output logic            mem_re,
  output logic            mem_we,
  output logic [7:0]      mem_wdata,
  input  logic [7:0]      mem_rdata
);

  localparam logic [2:0] WAIT_LD =
    (WAIT_STATES > WAIT_MAX) ? 3'(WAIT_MAX) : 3'(WAIT_STATES);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] ad_out_q, ad_out_d;
  logic [7:0] wdata_q, wdata_d;
  logic       re_q, re_d;
  logic       we_q, we_d;
  logic       err_q, err_d;

  ad_demux u_demux (
    .clk_i   (phi1),
    .rst_ni  (resetn),
    .ale_i   (bus.ALE),
    .ad_i    (bus.ad_in),
    .a_hi_i  (bus.a_hi),
    .iomn_i  (bus.IOMn),
    .s1_i    (bus.S1),
    .s0_i    (bus.S0),
    .addr_o  (mem_addr),
    .io_o    (mem_io),
    .fetch_o (fetch)
  );

  always_ff @(posedge phi1 or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ad_out_q <= '0;
      wdata_q  <= '0;
      re_q     <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ad_out_q <= ad_out_d;
      wdata_q  <= wdata_d;
      re_q     <= re_d;
      we_q     <= we_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ad_out_d = ad_out_q;
    wdata_d  = wdata_q;
    re_d     = 1'b0;
    we_d     = 1'b0;
    err_d    = 1'b0;

    if (bus.ALE) begin
      state_d = ST_ADDR;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_ADDR: begin
          if (!bus.RDn && !bus.WRn) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else if (!bus.RDn) begin
            cnt_d   = WAIT_LD;
            re_d    = 1'b1;
            state_d = ST_RD_WAIT;
          end else if (!bus.WRn) begin
            cnt_d = WAIT_LD;
            // With no wait states the write commits on the strobe edge itself
            if (WAIT_LD == 3'd0) begin
              wdata_d = bus.ad_in;
              we_d    = 1'b1;
              state_d = ST_WR_DONE;
            end else begin
              state_d = ST_WR_WAIT;
            end
          end
        end
        ST_RD_WAIT: begin
          if (bus.RDn) begin
            state_d = ST_IDLE;
          end else begin
            // mem_rdata is only valid in the cycle mem_re is high
            if (re_q) ad_out_d = mem_rdata;
            cnt_d = sat_dec(cnt_q);
            if (cnt_q == 3'd0) state_d = ST_RD_DRIVE;
          end
        end
        ST_RD_DRIVE: begin
          if (bus.RDn) state_d = ST_IDLE;
        end
        ST_WR_WAIT: begin
          if (bus.WRn) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = sat_dec(cnt_q);
            if (sat_dec(cnt_q) == 3'd0) begin
              wdata_d = bus.ad_in;
              we_d    = 1'b1;
              state_d = ST_WR_DONE;
            end
          end
        end
        ST_WR_DONE: begin
          if (bus.WRn) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.ad_out = ad_out_q;
  assign bus.ad_oe  = ((state_q == ST_RD_WAIT) || (state_q == ST_RD_DRIVE)) && !bus.RDn;
  assign bus.READY  = !(((state_q == ST_RD_WAIT) || (state_q == ST_WR_WAIT)) && (cnt_q != 3'd0));
  assign bus_err    = err_q;
  assign mem_re     = re_q;
  assign mem_we     = we_q;
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_bus_responder.sv
// Bench for bus_responder: four instances (W=0,2,3,4) share one CPU stimulus stream.
module tb_bus_responder;
  import bus_pkg::*;

  localparam int NDUT = 4;
  localparam logic [NDUT-1:0][2:0] WS = {3'd4, 3'd3, 3'd2, 3'd0};

  logic phi1 = 1'b0;
  logic resetn = 1'b0;
  always #5 phi1 = ~phi1;

  logic       ale = 1'b0, iomn = 1'b0, s1 = 1'b0, s0 = 1'b0, rdn = 1'b1, wrn = 1'b1;
  logic [7:0] ad_in = 8'h00, a_hi = 8'h00;

  logic [7:0]  ad_out_w [NDUT];
  logic        ad_oe_w  [NDUT];
  logic        ready_w  [NDUT];
  logic        fetch_w  [NDUT];
  logic        err_w    [NDUT];
  logic        io_w     [NDUT];
  logic        re_w     [NDUT];
  logic        we_w     [NDUT];
  logic [15:0] addr_w   [NDUT];
  logic [7:0]  wdata_w  [NDUT];
  logic [7:0]  rdata_w  [NDUT];

  function automatic logic [7:0] rd_fn(input logic [15:0] a);
    return (a == 16'h1234) ? 8'h3E : (a[7:0] ^ {a[14:8], a[15]} ^ 8'hC3);
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    bus_responder_if bif ();
    assign bif.ALE   = ale;
    assign bif.ad_in = ad_in;
    assign bif.a_hi  = a_hi;
    assign bif.IOMn  = iomn;
    assign bif.S1    = s1;
    assign bif.S0    = s0;
    assign bif.RDn   = rdn;
    assign bif.WRn   = wrn;
    assign ad_out_w[g] = bif.ad_out;
    assign ad_oe_w[g]  = bif.ad_oe;
    assign ready_w[g]  = bif.READY;
    // backing store answers only while the strobe is up
    assign rdata_w[g]  = re_w[g] ? rd_fn(addr_w[g]) : 8'h00;

    bus_responder #(.WAIT_STATES(32'(WS[g]))) dut (
      .phi1      (phi1),
      .resetn    (resetn),
      .bus       (bif),
      .fetch     (fetch_w[g]),
      .bus_err   (err_w[g]),
      .mem_addr  (addr_w[g]),
      .mem_io    (io_w[g]),
      .mem_re    (re_w[g]),
      .mem_we    (we_w[g]),
      .mem_wdata (wdata_w[g]),
      .mem_rdata (rdata_w[g])
    );
  end

  typedef enum int {K_RD, K_WR, K_ERR} kind_e;
  typedef struct {
    kind_e       kind;
    logic [15:0] addr;
    logic        iom;
    logic [1:0]  st;
    int          L;        // cycles the strobe is held low from e0
    int          G;        // extra strobe-high cycles after release
    bit          b2b;      // next ALE lands in this transaction's last cycle
    logic [7:0]  wd;
    bit          rnd_wd;
    logic        exp_fetch;
    logic [7:0]  exp_val;  // ad_out after reads/errors, W=2 mem_wdata after writes
  } txn_t;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_addr = '0;
  logic        exp_fetch = 1'b0, exp_io = 1'b0;
  logic [7:0]  exp_ad_out = '0;
  logic [7:0]  exp_wdata [NDUT];
  logic [7:0]  wd_at [NDUT];

  task automatic chk(input string nm, input int g, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s dut%0d got %h expected %h at %0t", nm, g, act, exp, $time);
    end
  endtask

  task automatic check_all(input int g, input bit e_re, input bit e_we, input bit e_err,
                           input bit e_rdy, input bit e_oe);
    chk("mem_re", g, 16'(re_w[g]), 16'(e_re));
    chk("mem_we", g, 16'(we_w[g]), 16'(e_we));
    chk("bus_err", g, 16'(err_w[g]), 16'(e_err));
    chk("READY", g, 16'(ready_w[g]), 16'(e_rdy));
    chk("ad_oe", g, 16'(ad_oe_w[g]), 16'(e_oe));
    chk("ad_out", g, 16'(ad_out_w[g]), 16'(exp_ad_out));
    chk("mem_wdata", g, 16'(wdata_w[g]), 16'(exp_wdata[g]));
    chk("mem_addr", g, addr_w[g], exp_addr);
    chk("fetch", g, 16'(fetch_w[g]), 16'(exp_fetch));
    chk("mem_io", g, 16'(io_w[g]), 16'(exp_io));
  endtask

  // j counts cycles from the e0 cycle (j=0 is the first strobe-low cycle, j=-1 the ALE cycle).
  task automatic run_txn(input txn_t t, input bit ale_done, input txn_t nx, input bit nx_b2b);
    txn_t src;
    int   W;
    for (int j = (ale_done ? 0 : -1); j <= t.L + t.G; j++) begin
      @(negedge phi1);
      ale = (j == -1) || (nx_b2b && j == t.L + t.G);
      if (ale) begin
        src  = (j == -1) ? t : nx;
        a_hi = src.addr[15:8];
        ad_in = src.addr[7:0];
        iomn = src.iom;
        {s1, s0} = src.st;
      end else begin
        ad_in = (t.kind == K_WR) ? (t.rnd_wd ? 8'($urandom) : t.wd) : 8'h00;
      end
      rdn = !((t.kind != K_WR) && j >= 0 && j < t.L);
      wrn = !((t.kind != K_RD) && j >= 0 && j < t.L);
      #1;
      if (j == 0) begin
        exp_addr  = t.addr;
        exp_fetch = (t.st == 2'b11);
        exp_io    = t.iom;
      end
      if (t.kind == K_RD && j == 2 && t.L >= 2) exp_ad_out = rd_fn(t.addr);
      for (int g = 0; g < NDUT; g++) begin
        W = int'(WS[g]);
        if (t.kind == K_WR && j == W + 1 && t.L >= W + 1) exp_wdata[g] = wd_at[g];
        check_all(g,
                  t.kind == K_RD && j == 1,
                  t.kind == K_WR && j == W + 1 && t.L >= W + 1,
                  t.kind == K_ERR && j == 1,
                  !(t.kind != K_ERR && j >= 1 && j <= W && j <= t.L),
                  t.kind == K_RD && j >= 1 && j <= t.L - 1);
        if (t.kind == K_WR && j == W) wd_at[g] = ad_in;
      end
    end
  endtask

  task automatic run_seq(input txn_t q[$], input bit tbl_checks);
    txn_t nx;
    for (int i = 0; i < q.size(); i++) begin
      nx = (i + 1 < q.size()) ? q[i + 1] : q[i];
      run_txn(q[i], (i > 0) && q[i - 1].b2b, nx, q[i].b2b && (i + 1 < q.size()));
      if (tbl_checks) begin
        chk("tbl_addr", 1, addr_w[1], q[i].addr);
        chk("tbl_fetch", 1, 16'(fetch_w[1]), 16'(q[i].exp_fetch));
        if (q[i].kind == K_WR) chk("tbl_wdata", 1, 16'(wdata_w[1]), 16'(q[i].exp_val));
        else                   chk("tbl_ad_out", 1, 16'(ad_out_w[1]), 16'(q[i].exp_val));
      end
    end
  endtask

  task automatic reset_model();
    exp_addr = '0; exp_fetch = 1'b0; exp_io = 1'b0; exp_ad_out = '0;
    for (int g = 0; g < NDUT; g++) exp_wdata[g] = '0;
  endtask

  initial begin
    txn_t tbl[$];
    txn_t rq[$];
    txn_t r;

    tbl.push_back('{K_RD,  16'h1234, 1'b0, 2'b11, 4, 1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h3E});
    tbl.push_back('{K_WR,  16'h2000, 1'b0, 2'b01, 5, 1, 1'b0, 8'hA5, 1'b0, 1'b0, 8'hA5});
    tbl.push_back('{K_RD,  16'h4040, 1'b1, 2'b10, 6, 1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h03});
    tbl.push_back('{K_ERR, 16'h00FF, 1'b0, 2'b10, 2, 1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h03});
    tbl.push_back('{K_WR,  16'h3000, 1'b0, 2'b01, 2, 1, 1'b0, 8'h5A, 1'b0, 1'b0, 8'hA5});
    tbl.push_back('{K_RD,  16'h0001, 1'b0, 2'b10, 3, 0, 1'b1, 8'h00, 1'b0, 1'b0, 8'hC2});
    tbl.push_back('{K_WR,  16'h0002, 1'b0, 2'b01, 5, 1, 1'b0, 8'h77, 1'b0, 1'b0, 8'h77});

    reset_model();
    for (int g = 0; g < NDUT; g++) wd_at[g] = '0;

    @(negedge phi1);
    @(negedge phi1);
    #1;
    for (int g = 0; g < NDUT; g++) check_all(g, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge phi1);
    resetn = 1'b1;

    run_seq(tbl, 1'b1);

    // reset asserted while the W=4 instance is driving read data
    @(negedge phi1);
    ale = 1'b1; {a_hi, ad_in} = 16'h5555; iomn = 1'b0; {s1, s0} = 2'b10;
    for (int j = 0; j < 7; j++) begin
      @(negedge phi1);
      ale = 1'b0; ad_in = 8'h00; rdn = 1'b0;
      #1;
      if (j == 6) begin
        chk("pre_rst_oe", 3, 16'(ad_oe_w[3]), 16'd1);
        chk("pre_rst_data", 3, 16'(ad_out_w[3]), 16'(rd_fn(16'h5555)));
      end
    end
    @(negedge phi1);
    resetn = 1'b0;
    #1;
    reset_model();
    for (int g = 0; g < NDUT; g++) check_all(g, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge phi1);
    resetn = 1'b1;
    rdn = 1'b1;

    for (int i = 0; i < 150; i++) begin
      int k;
      k = int'($urandom_range(0, 9));
      r.kind      = (k < 5) ? K_RD : ((k < 9) ? K_WR : K_ERR);
      r.addr      = 16'($urandom);
      r.iom       = 1'($urandom);
      r.st        = 2'($urandom);
      r.L         = int'($urandom_range(1, 8));
      r.G         = int'($urandom_range(0, 2));
      r.b2b       = 1'($urandom);
      r.wd        = 8'h00;
      r.rnd_wd    = 1'b1;
      r.exp_fetch = 1'b0;
      r.exp_val   = 8'h00;
      rq.push_back(r);
    end
    run_seq(rq, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
